spi_xfer_ctrl: RTL
==================

// Module: spi_xfer_ctrl
// PURPOSE
//  Sequencer for the SPI peripheral. Reads the control word and walks the data register RAM byte by byte.
//  For each byte: fetches the TX byte, shifts it out on MOSI, captures MISO and writes the RX byte back
//  to the same RAM address. Holds the RAM port (hold_ctrl_o) for the whole transfer.
//  Writes completion status back to the control register.
// PARAMETERS
//  DIV     2   clk_i cycles per SCK half-period (>=1); one bit = 2*DIV clks
//  ADDR_W  10  data RAM address width
// PORTS
//  clk_i        in   1       system clock (10 MHz)
//  rst_i        in   1       synchronous, active-high reset
//  ctrl_i       in   32      control register contents
//  ctrl_o       out  32      control word written back at end of transfer
//  ctrl_we_o    out  1       one-cycle write strobe for ctrl_o
//  dat_rd_i     in   32      data RAM read port (byte in [7:0])
//  dat_wr_o     out  32      RX byte, zero-extended
//  dat_we_o     out  1       data RAM write enable
//  dat_addr_o   out  ADDR_W  data RAM address
//  hold_ctrl_o  out  1       1 = this block owns the data RAM port
//  sck_o        out  1       SPI clock, mode 0 (idle low)
//  mosi_o       out  1       SPI data out, MSB first
//  miso_i       in   1       SPI data in
//  cs_o         out  1       chip select, active low
//  busy_o       out  1       transfer in progress
// BEHAVIOUR
//  Control fields:
//   [0] send | [1] cs_ctrl (1 = cs_o forced low in IDLE) | [2] all_1s | [3] all_0s
//   [12:4] n_tx_end (last byte index) | [25:16] n_rx (written back)
//  Reset values: cs_o=1, sck_o=0, mosi_o=0; all other outputs 0; state IDLE.
//  FSM:
//   IDLE    send=1 -> RD_REQ. idx=0, hold_ctrl_o=1, busy_o=1, cs_o=0.
//   RD_REQ  dat_addr_o=idx, dat_we_o=0 -> RD_WAIT.
//   RD_WAIT One clock of RAM read latency. Load the shifter:
//           all_1s ? 8'hFF : all_0s ? 8'h00 : dat_rd_i[7:0]. -> SHIFT.
//   SHIFT   8 bits, 16*DIV clks. MOSI changes while SCK is low; MISO is sampled on the SCK rising edge.
//           sck_o returns low after bit 7 -> WR_BACK.
//   WR_BACK dat_addr_o=idx, dat_wr_o={24'b0,rx}, dat_we_o=1 for exactly one clk.
//           idx==n_tx_end ? DONE : (idx++, RD_REQ).
//   DONE    ctrl_o = ctrl_i with bit0 cleared and [25:16]=idx+1; ctrl_we_o=1 for one clk.
//           hold_ctrl_o=0, busy_o=0. cs_o = ~cs_ctrl. -> IDLE.
//  Per-byte latency: 16*DIV+3 clks. Total = (n_tx_end+1)*(16*DIV+3)+1.
//  Edge cases:
//   - all_1s and all_0s both set: all_1s wins.
//   - n_tx_end=0: 1 byte. n_tx_end=511: 512 bytes, no address wrap.
//   - ctrl_i is sampled once in IDLE. Later changes, including send dropping, are ignored until DONE.
//   - send still 1 on the clk after DONE: no retrigger, because DONE cleared it.
//   - rst_i mid-transfer: IDLE next clk, cs_o=1, no further RAM or ctrl writes. RAM contents are undefined.
// CONFIGURATION
//  SPI_LOOPBACK_EN defined: the shifter input is mosi_o and miso_i is ignored, so RX byte == TX byte.
//  Not defined: miso_i is used.
// STRUCTURE
//  Package spi_pkg:
//   - state_t enum
//   - control-field bit positions/widths (CTRL_SEND, CTRL_CS, CTRL_ALL1, CTRL_ALL0, CTRL_NTX_*, CTRL_NRX_*)
//  Sub-module spi_shift_engine:
//   - SCK divider, 8-bit TX/RX shift registers, bit counter
//   - load/start in, done pulse out
// TESTING
//  1. send=1, n_tx_end=0, RAM[0]=8'hA5, loopback -> mosi 1010_0101; RAM[0]=8'hA5;
//     ctrl_o[0]=0, n_rx=1; ctrl_we_o 1 clk.
//  2. n_tx_end=3, RAM[0..3]=01,02,03,04, miso model returns ~tx -> RAM[0..3]=FE,FD,FC,FB;
//     n_rx=4; busy_o 4*(16*DIV+3) clks.
//  3. all_1s=1 and all_0s=1, RAM[0]=8'h00 -> MOSI 8'hFF; no RAM read data used.
//  4. rst_i asserted 5 clks into SHIFT of byte 1 -> next clk cs_o=1, hold_ctrl_o=0; dat_we_o and ctrl_we_o stay 0.
//  5. cs_ctrl=1, send=0 -> cs_o=0 in IDLE; sck_o stays 0, no writes.
//  6. n_tx_end=511 -> 512 writes, last dat_addr_o=511, n_rx=512.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and control-word field positions for the SPI transfer sequencer.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_SHIFT,
    S_WR_BACK,
    S_DONE
  } state_t;

  localparam int CTRL_SEND    = 0;
  localparam int CTRL_CS      = 1;
  localparam int CTRL_ALL1    = 2;
  localparam int CTRL_ALL0    = 3;
  localparam int CTRL_NTX_LSB = 4;
  localparam int CTRL_NTX_W   = 9;
  localparam int CTRL_NRX_LSB = 16;
  localparam int CTRL_NRX_W   = 10;

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 byte shifter: SCK divider, MSB-first TX/RX shift registers, bit counter.
// SPI_LOOPBACK_EN defined: RX samples mosi instead of miso.
module spi_shift_engine #(
  parameter int DIV = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr, rx_sr;
  logic          active, half_end, sin;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign sin         = mosi;
`else
  assign sin         = miso;
`endif

  assign half_end = active && (div_cnt == CW'(DIV - 1));
  // done coincides with the edge that drops SCK after bit 7
  assign done     = half_end && sck && (bit_cnt == 3'd7);
  assign rx_byte  = rx_sr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active  <= 1'b0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
    end else if (load) begin
      active  <= 1'b1;
      sck     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= tx_byte;
      mosi    <= tx_byte[7];
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!sck) begin
          sck   <= 1'b1;
          rx_sr <= {rx_sr[6:0], sin};
        end else begin
          sck <= 1'b0;
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_sr   <= {tx_sr[6:0], 1'b0};
            mosi    <= tx_sr[6];
          end
        end
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: walks data RAM bytes through the shift engine and writes status back.
// Build option SPI_LOOPBACK_EN (in spi_shift_engine) routes MOSI back to the RX shifter.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DIV    = 2,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       ctrl_i,
  output logic [31:0]       ctrl_o,
  output logic              ctrl_we_o,
  input  logic [31:0]       dat_rd_i,
  output logic [31:0]       dat_wr_o,
  output logic              dat_we_o,
  output logic [ADDR_W-1:0] dat_addr_o,
  output logic              hold_ctrl_o,
  output logic              sck_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_o,
  output logic              busy_o
);

  state_t                  state, state_nxt;
  logic [31:0]             ctrl_q;
  logic [ADDR_W-1:0]       idx;
  logic [7:0]              tx_byte, rx_byte;
  logic                    eng_load, eng_done, last;
  logic [CTRL_NRX_W-1:0]   n_rx;
  logic                    unused_rd;

  assign unused_rd  = ^dat_rd_i[31:8];
  assign last       = (idx == ADDR_W'(ctrl_q[CTRL_NTX_LSB +: CTRL_NTX_W]));
  assign n_rx       = CTRL_NRX_W'(idx) + CTRL_NRX_W'(1);
  assign dat_addr_o = idx;
  // all_1s has priority over all_0s
  assign tx_byte    = ctrl_q[CTRL_ALL1] ? 8'hFF :
                      ctrl_q[CTRL_ALL0] ? 8'h00 : dat_rd_i[7:0];

  spi_shift_engine #(.DIV(DIV)) u_eng (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (eng_load),
    .tx_byte (tx_byte),
    .miso    (miso_i),
    .sck     (sck_o),
    .mosi    (mosi_o),
    .rx_byte (rx_byte),
    .done    (eng_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (ctrl_i[CTRL_SEND]) state_nxt = S_RD_REQ;
      S_RD_REQ:  state_nxt = S_RD_WAIT;
      S_RD_WAIT: state_nxt = S_SHIFT;
      S_SHIFT:   if (eng_done) state_nxt = S_WR_BACK;
      S_WR_BACK: state_nxt = last ? S_DONE : S_RD_REQ;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state != S_IDLE) && (state != S_DONE);
    hold_ctrl_o = busy_o;
    eng_load    = (state == S_RD_WAIT);
    dat_we_o    = (state == S_WR_BACK);
    dat_wr_o    = dat_we_o ? {24'b0, rx_byte} : 32'b0;
    ctrl_we_o   = (state == S_DONE);
    ctrl_o      = 32'b0;
    if (ctrl_we_o) begin
      ctrl_o                                = ctrl_q;
      ctrl_o[CTRL_SEND]                     = 1'b0;
      ctrl_o[CTRL_NRX_LSB +: CTRL_NRX_W]    = n_rx;
    end
  end

  // Control word is captured once at start; cs_o follows the live cs_ctrl only while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      idx    <= '0;
      cs_o   <= 1'b1;
    end else begin
      if (state == S_IDLE && ctrl_i[CTRL_SEND]) begin
        ctrl_q <= ctrl_i;
        idx    <= '0;
      end
      if (state == S_WR_BACK && !last) idx <= idx + ADDR_W'(1);
      case (state_nxt)
        S_IDLE:  cs_o <= ~ctrl_i[CTRL_CS];
        S_DONE:  cs_o <= ~ctrl_q[CTRL_CS];
        default: cs_o <= 1'b0;
      endcase
    end
  end

endmodule
